// File: rtl/pmbus_cmd_sequencer_pkg.sv
// Purpose: shared types, PMBus command codes and the default power-up command table.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pmbus_cmd_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_GAP   = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } seq_state_t;

    localparam logic [7:0] CMD_PAGE                = 8'h00;
    localparam logic [7:0] CMD_OPERATION           = 8'h01;
    localparam logic [7:0] CMD_ON_OFF_CONFIG       = 8'h02;
    localparam logic [7:0] CMD_VOUT_COMMAND        = 8'h21;
    localparam logic [7:0] CMD_VOUT_MAX            = 8'h24;
    localparam logic [7:0] CMD_IOUT_OC_FAULT_LIMIT = 8'h46;

    typedef struct packed {
        logic [7:0]  cmd;
        logic [1:0]  len;
        logic [15:0] data;
    } cmd_entry_t;

    // Bring-up order: select page, arm on/off control, clamp VOUT_MAX before
    // programming VOUT, set the OC limit, and only then switch the rail on.
    function automatic cmd_entry_t default_entry(input logic [3:0] idx);
        cmd_entry_t e;
        e = '0;
        case (idx)
            4'd0:    e = '{cmd: CMD_PAGE,                len: 2'd1, data: 16'h0000};
            4'd1:    e = '{cmd: CMD_ON_OFF_CONFIG,       len: 2'd1, data: 16'h001A};
            4'd2:    e = '{cmd: CMD_VOUT_MAX,            len: 2'd2, data: 16'h0300};
            4'd3:    e = '{cmd: CMD_VOUT_COMMAND,        len: 2'd2, data: 16'h0266};
            4'd4:    e = '{cmd: CMD_IOUT_OC_FAULT_LIMIT, len: 2'd2, data: 16'hF828};
            4'd5:    e = '{cmd: CMD_OPERATION,           len: 2'd1, data: 16'h0080};
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/pmbus_cmd_sequencer_rom.sv
// Purpose: command table lookup, step index in, {cmd, len, data} out.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows the index continuously.
module pmbus_cmd_rom
    import pmbus_cmd_sequencer_pkg::*;
(
    input  logic [3:0]  step,
    output logic [7:0]  cmd,
    output logic [1:0]  len,
    output logic [15:0] data
);

    cmd_entry_t entry;

    // Table lookup; indices past the table return an empty zero-length entry.
    always_comb begin
        entry = default_entry(step);
    end

    assign cmd  = entry.cmd;
    assign len  = entry.len;
    assign data = entry.data;

endmodule

// File: rtl/pmbus_cmd_sequencer.sv
// Purpose: walk the PMBus command table, issuing one write per step with retry, gap and timeout.
// Latency: start->first O_wr_pulse 2 cycles; completion->next issue GAP_CYC+2 cycles.
// Backpressure: waits on I_fh_pulse per command; I_start ignored while busy.
module pmbus_cmd_sequencer
    import pmbus_cmd_sequencer_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h24,
    parameter int         N_STEPS     = 6,
    parameter int         GAP_CYC     = 4000,
    parameter int         TIMEOUT_CYC = 40000,
    parameter int         MAX_RETRY   = 3
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_start,
    output logic        O_wr_pulse,
    output logic [6:0]  O_addr,
    output logic [7:0]  O_cmd,
    output logic [15:0] O_data,
    output logic [1:0]  O_len,
    input  logic        I_fh_pulse,
    input  logic        I_nack,
    output logic        O_busy,
    output logic        O_done,
    output logic        O_err,
    output logic        O_cntl,
    output logic [3:0]  O_step
);

    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYC - 1);
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYC - 1);
    localparam logic [15:0] RETRY_MAX = 16'(MAX_RETRY);
    localparam logic [3:0]  STEP_LAST = 4'(N_STEPS - 1);

    seq_state_t  state;
    logic [3:0]  step;
    logic [15:0] retry;
    logic [15:0] gap_cnt;
    logic [15:0] to_cnt;
    logic        reissue;

    logic [7:0]  rom_cmd;
    logic [1:0]  rom_len;
    logic [15:0] rom_data;

    logic        wait_ok;
    logic        wait_fail;

    pmbus_cmd_rom u_rom (
        .step (step),
        .cmd  (rom_cmd),
        .len  (rom_len),
        .data (rom_data)
    );

    // A writer response always wins over a timeout landing in the same cycle.
    assign wait_ok   = I_fh_pulse & ~I_nack;
    assign wait_fail = I_fh_pulse ? I_nack : (to_cnt == TO_LAST);

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state      <= ST_IDLE;
            step       <= '0;
            retry      <= '0;
            gap_cnt    <= '0;
            to_cnt     <= '0;
            reissue    <= 1'b0;
            O_wr_pulse <= 1'b0;
            O_addr     <= DEV_ADDR;
            O_cmd      <= '0;
            O_data     <= '0;
            O_len      <= '0;
            O_busy     <= 1'b0;
            O_done     <= 1'b0;
            O_err      <= 1'b0;
            O_cntl     <= 1'b0;
            O_step     <= '0;
        end else begin
            O_wr_pulse <= 1'b0;
            O_done     <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (I_start) begin
                        state   <= ST_LOAD;
                        step    <= '0;
                        retry   <= '0;
                        reissue <= 1'b0;
                        O_step  <= '0;
                        O_err   <= 1'b0;
                        O_cntl  <= 1'b0;
                        O_busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    // Command fields are captured only here, so they hold
                    // steady for the writer through ISSUE and WAIT.
                    O_addr     <= DEV_ADDR;
                    O_cmd      <= rom_cmd;
                    O_len      <= rom_len;
                    O_data     <= rom_data;
                    O_step     <= step;
                    O_wr_pulse <= 1'b1;
                    state      <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    to_cnt <= '0;
                    state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_ok) begin
                        retry   <= '0;
                        reissue <= 1'b0;
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end else if (wait_fail) begin
                        if (retry == RETRY_MAX) begin
                            state  <= ST_ERR;
                            O_err  <= 1'b1;
                            O_cntl <= 1'b0;
                            O_busy <= 1'b0;
                        end else begin
                            retry   <= retry + 16'd1;
                            reissue <= 1'b1;
                            gap_cnt <= '0;
                            state   <= ST_GAP;
                        end
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        if (reissue) begin
                            state <= ST_LOAD;
                        end else if (step == STEP_LAST) begin
                            state  <= ST_DONE;
                            O_done <= 1'b1;
                            O_cntl <= 1'b1;
                            O_busy <= 1'b0;
                        end else begin
                            step  <= step + 4'd1;
                            state <= ST_LOAD;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    O_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmbus_cmd_sequencer.sv
module tb_pmbus_cmd_sequencer;

    localparam int GAP     = 10;
    localparam int TMO     = 50;
    localparam int RETRIES = 3;

    logic        I_clk = 1'b0;
    logic        I_rst = 1'b1;
    logic        I_start = 1'b0;
    logic        I_fh_pulse = 1'b0;
    logic        I_nack = 1'b0;
    logic        O_wr_pulse;
    logic [6:0]  O_addr;
    logic [7:0]  O_cmd;
    logic [15:0] O_data;
    logic [1:0]  O_len;
    logic        O_busy;
    logic        O_done;
    logic        O_err;
    logic        O_cntl;
    logic [3:0]  O_step;

    pmbus_cmd_sequencer #(
        .DEV_ADDR    (7'h24),
        .N_STEPS     (6),
        .GAP_CYC     (GAP),
        .TIMEOUT_CYC (TMO),
        .MAX_RETRY   (RETRIES)
    ) dut (
        .I_clk      (I_clk),
        .I_rst      (I_rst),
        .I_start    (I_start),
        .O_wr_pulse (O_wr_pulse),
        .O_addr     (O_addr),
        .O_cmd      (O_cmd),
        .O_data     (O_data),
        .O_len      (O_len),
        .I_fh_pulse (I_fh_pulse),
        .I_nack     (I_nack),
        .O_busy     (O_busy),
        .O_done     (O_done),
        .O_err      (O_err),
        .O_cntl     (O_cntl),
        .O_step     (O_step)
    );

    always #5 I_clk = ~I_clk;

    typedef struct {
        logic [7:0]  cmd;
        logic [1:0]  len;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        int nack_step;
        int nack_cnt;
        bit silent;
        int delay;
        bit poke;
        int exp_wr;
        int exp_done;
        int exp_err;
        int exp_step;
        int exp_cntl;
        int exp_spacing;
    } vec_t;

    exp_t rom_tab [6];
    vec_t vecs    [8];
    exp_t sb [$];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    int   wr_cnt, done_cnt;
    int   prev_wr, exp_spacing;
    bit   have_prev;
    bit   w_silent;
    int   w_delay;
    logic [7:0] nack_cmd;
    int   nack_left;
    bit   fh_pending, fh_nack;
    int   fh_at, last_fh_cyc;
    bit   nack_gap_pending;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // One clock: observe DUT outputs after the edge, then act as the PMBus writer.
    task automatic tick();
        exp_t e;
        @(posedge I_clk);
        #1;
        cyc++;
        if (O_done) done_cnt++;
        if (O_wr_pulse) begin
            wr_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_issue", 1, 0);
            end else begin
                e = sb.pop_front();
                check("issue_cmd", O_cmd, e.cmd);
                check("issue_len", O_len, e.len);
                check("issue_data", O_data, e.data);
                check("issue_addr", O_addr, 7'h24);
            end
            if (have_prev) check("wr_spacing", cyc - prev_wr, exp_spacing);
            prev_wr   = cyc;
            have_prev = 1'b1;
            if (nack_gap_pending) begin
                // GAP cycles, then LOAD, then the ISSUE cycle carrying the pulse
                check("nack_to_reissue", cyc - last_fh_cyc, GAP + 2);
                nack_gap_pending = 1'b0;
            end
            if (!w_silent) begin
                fh_pending = 1'b1;
                fh_at      = cyc + w_delay;
                fh_nack    = (O_cmd == nack_cmd) && (nack_left > 0);
                if (fh_nack) nack_left--;
            end
        end
        if (fh_pending && cyc == fh_at) begin
            I_fh_pulse       = 1'b1;
            I_nack           = fh_nack;
            fh_pending       = 1'b0;
            last_fh_cyc      = cyc;
            nack_gap_pending = fh_nack;
        end else begin
            I_fh_pulse = 1'b0;
            I_nack     = 1'b0;
        end
    endtask

    // Expected issue stream: each step once, failing steps re-issued up to RETRIES times.
    task automatic push_expected(input vec_t v);
        int attempts;
        bit fail;
        for (int s = 0; s < 6; s++) begin
            attempts = 1;
            fail     = 1'b0;
            if (v.silent) begin
                attempts = RETRIES + 1;
                fail     = 1'b1;
            end else if (s == v.nack_step) begin
                if (v.nack_cnt > RETRIES) begin
                    attempts = RETRIES + 1;
                    fail     = 1'b1;
                end else begin
                    attempts = v.nack_cnt + 1;
                end
            end
            for (int a = 0; a < attempts; a++) sb.push_back(rom_tab[s]);
            if (fail) break;
        end
    endtask

    task automatic setup_writer(input vec_t v);
        w_silent         = v.silent;
        w_delay          = v.delay;
        nack_cmd         = (v.nack_step >= 0) ? rom_tab[v.nack_step].cmd : 8'hFF;
        nack_left        = (v.nack_step >= 0) ? v.nack_cnt : 0;
        fh_pending       = 1'b0;
        nack_gap_pending = 1'b0;
        wr_cnt           = 0;
        done_cnt         = 0;
        have_prev        = 1'b0;
        exp_spacing      = v.exp_spacing;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        bit finished;
        setup_writer(v);
        sb.delete();
        push_expected(v);
        I_start = 1'b1;
        tick();
        I_start = 1'b0;
        check("start_busy", O_busy, 1);
        check("start_clears_err", O_err, 0);
        check("start_clears_cntl", O_cntl, 0);
        finished = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (!O_busy) begin
                finished = 1'b1;
                break;
            end
            I_start = (v.poke && (n % 7 == 3)) ? 1'b1 : 1'b0;
        end
        I_start = 1'b0;
        if (!finished) check("run_timeout", idx, -1);
        for (int k = 0; k < 3; k++) tick();
        check("wr_count", wr_cnt, v.exp_wr);
        check("done_pulses", done_cnt, v.exp_done);
        check("err_level", O_err, v.exp_err);
        check("final_step", O_step, v.exp_step);
        check("cntl_level", O_cntl, v.exp_cntl);
        check("sb_drained", sb.size(), 0);
    endtask

    initial begin
        bit reached;
        rom_tab[0] = '{8'h00, 2'd1, 16'h0000};
        rom_tab[1] = '{8'h02, 2'd1, 16'h001A};
        rom_tab[2] = '{8'h24, 2'd2, 16'h0300};
        rom_tab[3] = '{8'h21, 2'd2, 16'h0266};
        rom_tab[4] = '{8'h46, 2'd2, 16'hF828};
        rom_tab[5] = '{8'h01, 2'd1, 16'h0080};

        //            nstep ncnt sil dly poke wr done err step cntl spacing
        vecs[0] = '{ -1,   0,  0,  20, 0,   6, 1,   0,  5,   1,   32 };  // all ACK
        vecs[1] = '{  3,   1,  0,  20, 0,   7, 1,   0,  5,   1,   32 };  // one NACK on VOUT_COMMAND
        vecs[2] = '{  2,  99,  0,  20, 0,   6, 0,   1,  2,   0,   32 };  // persistent NACK on VOUT_MAX
        vecs[3] = '{ -1,   0,  1,   0, 0,   4, 0,   1,  0,   0,   62 };  // silent writer
        vecs[4] = '{ -1,   0,  0,  50, 0,   6, 1,   0,  5,   1,   62 };  // ACK on timeout terminal count
        vecs[5] = '{ -1,   0,  0,  20, 1,   6, 1,   0,  5,   1,   32 };  // start pokes while busy
        vecs[6] = '{  0,   3,  0,  20, 0,   9, 1,   0,  5,   1,   32 };  // exactly MAX_RETRY NACKs
        vecs[7] = '{  5,   4,  0,  20, 0,   9, 0,   1,  5,   0,   32 };  // last step exhausts retries

        setup_writer(vecs[0]);

        I_rst = 1'b1;
        repeat (3) tick();
        check("rst_addr", O_addr, 7'h24);
        check("rst_busy", O_busy, 0);
        check("rst_wr", O_wr_pulse, 0);
        check("rst_cmd", O_cmd, 0);
        check("rst_data", O_data, 0);
        check("rst_len", O_len, 0);
        check("rst_flags", {O_done, O_err, O_cntl}, 0);
        check("rst_step", O_step, 0);
        I_rst = 1'b0;
        tick();
        check("idle_busy", O_busy, 0);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Reset while waiting on step 1's response; its late reply must be ignored.
        setup_writer(vecs[0]);
        sb.delete();
        sb.push_back(rom_tab[0]);
        sb.push_back(rom_tab[1]);
        I_start = 1'b1;
        tick();
        I_start = 1'b0;
        reached = 1'b0;
        for (int n = 0; n < 200; n++) begin
            tick();
            if (wr_cnt == 2) begin
                reached = 1'b1;
                break;
            end
        end
        check("rst_test_reached_step1", reached, 1);
        repeat (5) tick();
        check("step1_in_wait", O_busy, 1);
        I_rst = 1'b1;
        tick();
        I_rst = 1'b0;
        check("midrst_busy", O_busy, 0);
        check("midrst_step", O_step, 0);
        check("midrst_cmd", O_cmd, 0);
        check("midrst_addr", O_addr, 7'h24);
        repeat (60) tick();
        check("midrst_no_more_wr", wr_cnt, 2);
        check("midrst_stays_idle", O_busy, 0);
        check("midrst_no_done", done_cnt, 0);
        check("midrst_sb", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
